// File: rtl/clock_set_if.sv
// Bus bundle for clock_set_ctrl: 1 Hz tick, button pulses and time/mode display outputs.
// Optional 12-hour outputs are present when CLOCK_HOUR12_EN is defined.
interface clock_set_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] mode;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       blink;
  logic       rollover;
`ifdef CLOCK_HOUR12_EN
  logic [3:0] hours12;
  logic       pm;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  mode, hours, minutes, seconds, blink, rollover, hours12, pm
  );
  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output mode, hours, minutes, seconds, blink, rollover, hours12, pm
  );
`else
  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  mode, hours, minutes, seconds, blink, rollover
  );
  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output mode, hours, minutes, seconds, blink, rollover
  );
`endif
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-of-day clock with button-driven hour/minute setting and an idle timeout back to RUN.
// Define CLOCK_HOUR12_EN to add the registered 12-hour outputs (hours12, pm).
module clock_set_ctrl #(
  parameter int unsigned SET_TIMEOUT = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  clock_set_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] hours, hours_nxt;
  logic [5:0] minutes, minutes_nxt;
  logic [5:0] seconds, seconds_nxt;
  logic       blink, blink_nxt;
  logic       rollover, rollover_nxt;
  logic [5:0] tcnt, tcnt_nxt;

  logic [4:0] hr_inc;
  logic [5:0] min_inc;
  logic [5:0] sec_inc;

  assign hr_inc  = (hours   == 5'd23) ? '0 : hours   + 5'd1;
  assign min_inc = (minutes == 6'd59) ? '0 : minutes + 6'd1;
  assign sec_inc = (seconds == 6'd59) ? '0 : seconds + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      blink    <= 1'b0;
      rollover <= 1'b0;
      tcnt     <= '0;
    end else begin
      state    <= state_nxt;
      hours    <= hours_nxt;
      minutes  <= minutes_nxt;
      seconds  <= seconds_nxt;
      blink    <= blink_nxt;
      rollover <= rollover_nxt;
      tcnt     <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hours_nxt    = hours;
    minutes_nxt  = minutes;
    seconds_nxt  = seconds;
    blink_nxt    = blink;
    rollover_nxt = 1'b0;
    tcnt_nxt     = tcnt;

    case (state)
      RUN: begin
        blink_nxt = 1'b0;
        // Time keeps running on the cycle btn_mode leaves RUN; btn_inc is ignored here.
        if (bus.tick_1hz) begin
          seconds_nxt = sec_inc;
          if (seconds == 6'd59) begin
            minutes_nxt = min_inc;
            if (minutes == 6'd59) begin
              hours_nxt = hr_inc;
              if (hours == 5'd23) rollover_nxt = 1'b1;
            end
          end
        end
        if (bus.btn_mode) begin
          state_nxt = SET_HR;
          blink_nxt = 1'b1;
          tcnt_nxt  = '0;
        end
      end

      SET_HR, SET_MIN: begin
        if (bus.btn_mode) begin
          tcnt_nxt = '0;
          if (state == SET_HR) begin
            state_nxt = SET_MIN;
            blink_nxt = 1'b1;
          end else begin
            state_nxt   = RUN;
            blink_nxt   = 1'b0;
            seconds_nxt = '0;
          end
        end else if (bus.btn_inc) begin
          tcnt_nxt = '0;
          if (bus.tick_1hz) blink_nxt = ~blink;
          if (state == SET_HR) hours_nxt   = hr_inc;
          else                 minutes_nxt = min_inc;
        end else if (bus.tick_1hz) begin
          // Leave on the edge that samples the final tick so mode follows it by one cycle.
          if (tcnt == 6'(SET_TIMEOUT - 1)) begin
            state_nxt   = RUN;
            blink_nxt   = 1'b0;
            seconds_nxt = '0;
            tcnt_nxt    = '0;
          end else begin
            tcnt_nxt  = tcnt + 6'd1;
            blink_nxt = ~blink;
          end
        end
      end

      default: begin
        state_nxt   = RUN;
        blink_nxt   = 1'b0;
        seconds_nxt = '0;
        tcnt_nxt    = '0;
      end
    endcase
  end

  assign bus.mode     = state;
  assign bus.hours    = hours;
  assign bus.minutes  = minutes;
  assign bus.seconds  = seconds;
  assign bus.blink    = blink;
  assign bus.rollover = rollover;

`ifdef CLOCK_HOUR12_EN
  logic [3:0] hours12, hours12_nxt;
  logic       pm, pm_nxt;

  always_comb begin
    hours12_nxt = 4'(hours_nxt);
    if (hours_nxt == 5'd0)       hours12_nxt = 4'd12;
    else if (hours_nxt > 5'd12)  hours12_nxt = 4'(hours_nxt - 5'd12);
    pm_nxt = (hours_nxt >= 5'd12);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours12 <= 4'd12;
      pm      <= 1'b0;
    end else begin
      hours12 <= hours12_nxt;
      pm      <= pm_nxt;
    end
  end

  assign bus.hours12 = hours12;
  assign bus.pm      = pm;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: vector table plus hand sequences for wrap, timeout and reset.
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_set_if bus();

  clock_set_ctrl #(.SET_TIMEOUT(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic       t, m, i;
    logic [1:0] emode;
    logic [4:0] eh;
    logic [5:0] em, es;
    logic       eb, er;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [1:0] md, input logic [4:0] h,
                     input logic [5:0] mi, input logic [5:0] s, input logic b, input logic r);
    n_cmp++;
    if ({bus.mode, bus.hours, bus.minutes, bus.seconds, bus.blink, bus.rollover} !==
        {md, h, mi, s, b, r}) begin
      n_bad++;
      $display("FAIL %s: got mode=%0d %0d:%0d:%0d blink=%0b roll=%0b, want mode=%0d %0d:%0d:%0d blink=%0b roll=%0b",
               nm, bus.mode, bus.hours, bus.minutes, bus.seconds, bus.blink, bus.rollover,
               md, h, mi, s, b, r);
    end
  endtask

`ifdef CLOCK_HOUR12_EN
  task automatic chk12(input string nm, input logic [3:0] h12, input logic p);
    n_cmp++;
    if ({bus.hours12, bus.pm} !== {h12, p}) begin
      n_bad++;
      $display("FAIL %s: got hours12=%0d pm=%0b, want hours12=%0d pm=%0b",
               nm, bus.hours12, bus.pm, h12, p);
    end
  endtask
`endif

  task automatic step(input logic t, input logic m, input logic i);
    @(negedge clk);
    bus.tick_1hz = t;
    bus.btn_mode = m;
    bus.btn_inc  = i;
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  logic eb;

  initial begin
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;

    //              t     m     i     mode  h     m     s     blink roll
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 6'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 5'd0, 6'd0, 6'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 6'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'd1, 5'd0, 6'd0, 6'd2, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd1, 5'd0, 6'd0, 6'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 5'd1, 6'd0, 6'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd1, 5'd2, 6'd0, 6'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd2, 5'd2, 6'd0, 6'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd2, 5'd2, 6'd1, 6'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd2, 5'd2, 6'd1, 6'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 5'd2, 6'd1, 6'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 5'd2, 6'd1, 6'd1, 1'b0, 1'b0};

    #12;
    chk("reset", 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
`ifdef CLOCK_HOUR12_EN
    chk12("reset_12h", 4'd12, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      step(vecs[k].t, vecs[k].m, vecs[k].i);
      chk($sformatf("vec%0d", k), vecs[k].emode, vecs[k].eh, vecs[k].em, vecs[k].es,
          vecs[k].eb, vecs[k].er);
    end

    // Preload 22:58:17 from 02:01:01
    step(0, 1, 0);
    repeat (20) step(0, 0, 1);
    step(0, 1, 0);
    repeat (57) step(0, 0, 1);
    step(0, 1, 0);
    repeat (17) step(1, 0, 0);
    chk("preload_22_58_17", 2'd0, 5'd22, 6'd58, 6'd17, 1'b0, 1'b0);

    // Hour and minute wraps in set modes, no carry from minutes into hours
    step(0, 1, 0);
    repeat (3) step(0, 0, 1);
    chk("sethr_wrap", 2'd1, 5'd1, 6'd58, 6'd17, 1'b1, 1'b0);
    step(0, 1, 0);
    repeat (2) step(0, 0, 1);
    chk("setmin_wrap", 2'd2, 5'd1, 6'd0, 6'd17, 1'b1, 1'b0);
    step(0, 1, 0);
    chk("back_to_run", 2'd0, 5'd1, 6'd0, 6'd0, 1'b0, 1'b0);

    // Preload 23:59 then run up to midnight
    step(0, 1, 0);
    repeat (22) step(0, 0, 1);
    step(0, 1, 0);
    repeat (59) step(0, 0, 1);
    step(0, 1, 0);
    chk("preload_23_59", 2'd0, 5'd23, 6'd59, 6'd0, 1'b0, 1'b0);
    repeat (58) step(1, 0, 0);
    chk("at_23_59_58", 2'd0, 5'd23, 6'd59, 6'd58, 1'b0, 1'b0);
    step(1, 0, 0);
    chk("at_23_59_59", 2'd0, 5'd23, 6'd59, 6'd59, 1'b0, 1'b0);
    step(1, 0, 0);
    chk("rollover_pulse", 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
    step(0, 0, 0);
    chk("rollover_end", 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    // Timeout: restarted by btn_inc, then 30 idle ticks return to RUN
    repeat (5) step(1, 0, 0);
    chk("run_5s", 2'd0, 5'd0, 6'd0, 6'd5, 1'b0, 1'b0);
    step(0, 1, 0);
    eb = 1'b1;
    chk("enter_sethr", 2'd1, 5'd0, 6'd0, 6'd5, eb, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 0);
      eb = ~eb;
      chk($sformatf("blink_a%0d", k), 2'd1, 5'd0, 6'd0, 6'd5, eb, 1'b0);
    end
    step(0, 0, 1);
    chk("inc_restarts_timeout", 2'd1, 5'd1, 6'd0, 6'd5, eb, 1'b0);
    for (int k = 1; k <= 29; k++) begin
      step(1, 0, 0);
      eb = ~eb;
      chk($sformatf("blink_b%0d", k), 2'd1, 5'd1, 6'd0, 6'd5, eb, 1'b0);
    end
    step(0, 0, 0);
    chk("idle_no_timeout", 2'd1, 5'd1, 6'd0, 6'd5, eb, 1'b0);
    step(1, 0, 0);
    chk("timeout_to_run", 2'd0, 5'd1, 6'd0, 6'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of SET_MIN
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("in_setmin", 2'd2, 5'd1, 6'd1, 6'd0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0);
    chk("first_tick_after_reset", 2'd0, 5'd0, 6'd0, 6'd1, 1'b0, 1'b0);

`ifdef CLOCK_HOUR12_EN
    chk12("h0", 4'd12, 1'b0);
    step(0, 1, 0);
    repeat (11) step(0, 0, 1);
    chk12("h11", 4'd11, 1'b0);
    step(0, 0, 1);
    chk12("h12", 4'd12, 1'b1);
    step(0, 0, 1);
    chk12("h13", 4'd1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
